// File: rtl/pio_master_sequencer.sv
// pio_master_sequencer: executes WRITE / READ / POLL commands as single
// Avalon-MM transfers against a PIO slave without waitrequest, and returns
// a one-cycle response pulse per command.
// Optional feature macro: PIO_MASTER_POLL_EN enables the POLL operation
// (GAP state, elapsed counter, masked compare). Without it op 10 is illegal.
module pio_master_sequencer #(
  parameter int READ_LATENCY = 1,
  parameter int POLL_TIMEOUT = 1024,
  parameter int POLL_GAP     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_address,
  input  logic [31:0] cmd_data,
  input  logic [31:0] cmd_mask,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [2:0]  avm_address,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata
);

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_READ   = 2'b01;
  localparam logic [2:0] LAST_WAIT = 3'(READ_LATENCY - 1);

`ifdef PIO_MASTER_POLL_EN
  localparam logic [1:0] OP_POLL   = 2'b10;
  localparam int         ELAPSED_W = (POLL_TIMEOUT < 1) ? 1 : $clog2(POLL_TIMEOUT + 1);
  localparam int         GAP_W     = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);

  typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_WAIT, GAP, RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_WAIT, RESP} state_t;
`endif

  state_t      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        avm_cs_q, avm_cs_d;
  logic        avm_write_n_q, avm_write_n_d;
  logic [2:0]  avm_address_q, avm_address_d;
  logic [31:0] avm_writedata_q, avm_writedata_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;

`ifdef PIO_MASTER_POLL_EN
  // Latched command fields; POLL re-issues reads and compares against them.
  logic [1:0]           op_q, op_d;
  logic [2:0]           addr_q, addr_d;
  logic [31:0]          data_q, data_d;
  logic [31:0]          mask_q, mask_d;
  logic [ELAPSED_W-1:0] elapsed_q, elapsed_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic                 poll_match;

  // A zero mask always matches, so the first read completes the poll.
  assign poll_match = ((avm_readdata ^ data_q) & mask_q) == 32'd0;
`else
  // Without POLL, the bus output flops themselves hold the latched address
  // and write data, and the compare mask has no consumer.
  logic unused_mask;
  assign unused_mask = ^cmd_mask;
`endif

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_d         = state_q;
    avm_cs_d        = 1'b0;
    avm_write_n_d   = 1'b1;
    avm_address_d   = 3'd0;
    avm_writedata_d = 32'd0;
    rsp_valid_d     = 1'b0;
    rsp_data_d      = 32'd0;
    rsp_err_d       = 1'b0;
    wait_cnt_d      = wait_cnt_q;
`ifdef PIO_MASTER_POLL_EN
    op_d      = op_q;
    addr_d    = addr_q;
    data_d    = data_q;
    mask_d    = mask_q;
    gap_cnt_d = gap_cnt_q;
    elapsed_d = (elapsed_q == '1) ? elapsed_q : elapsed_q + 1'b1;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
`ifdef PIO_MASTER_POLL_EN
          op_d      = cmd_op;
          addr_d    = cmd_address;
          data_d    = cmd_data;
          mask_d    = cmd_mask;
          elapsed_d = '0;
`endif
          case (cmd_op)
            OP_WRITE: begin
              state_d         = WRITE;
              avm_cs_d        = 1'b1;
              avm_write_n_d   = 1'b0;
              avm_address_d   = cmd_address;
              avm_writedata_d = cmd_data;
            end
            OP_READ: begin
              state_d       = RD_ADDR;
              avm_cs_d      = 1'b1;
              avm_address_d = cmd_address;
            end
`ifdef PIO_MASTER_POLL_EN
            OP_POLL: begin
              state_d       = RD_ADDR;
              avm_cs_d      = 1'b1;
              avm_address_d = cmd_address;
            end
`endif
            default: begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
            end
          endcase
        end
      end
      WRITE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      RD_ADDR: begin
        state_d    = RD_WAIT;
        wait_cnt_d = 3'd0;
      end
      RD_WAIT: begin
        if (wait_cnt_q == LAST_WAIT) begin
`ifdef PIO_MASTER_POLL_EN
          if (op_q == OP_POLL && !poll_match) begin
            if (elapsed_q >= ELAPSED_W'(POLL_TIMEOUT)) begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
            end else if (POLL_GAP == 0) begin
              state_d       = RD_ADDR;
              avm_cs_d      = 1'b1;
              avm_address_d = addr_q;
            end else begin
              state_d   = GAP;
              gap_cnt_d = '0;
            end
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = avm_readdata;
          end
`else
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = avm_readdata;
`endif
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
`ifdef PIO_MASTER_POLL_EN
      GAP: begin
        if (gap_cnt_q == GAP_W'(POLL_GAP - 1)) begin
          state_d       = RD_ADDR;
          avm_cs_d      = 1'b1;
          avm_address_d = addr_q;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
`endif
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == IDLE);
  end

  // Single state register: FSM, registered outputs, latched fields, counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cmd_ready_q     <= 1'b1;
      busy_q          <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= 32'd0;
      rsp_err_q       <= 1'b0;
      avm_cs_q        <= 1'b0;
      avm_write_n_q   <= 1'b1;
      avm_address_q   <= 3'd0;
      avm_writedata_q <= 32'd0;
      wait_cnt_q      <= 3'd0;
`ifdef PIO_MASTER_POLL_EN
      op_q      <= 2'd0;
      addr_q    <= 3'd0;
      data_q    <= 32'd0;
      mask_q    <= 32'd0;
      elapsed_q <= '0;
      gap_cnt_q <= '0;
`endif
    end else begin
      state_q         <= state_d;
      cmd_ready_q     <= cmd_ready_d;
      busy_q          <= busy_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_err_q       <= rsp_err_d;
      avm_cs_q        <= avm_cs_d;
      avm_write_n_q   <= avm_write_n_d;
      avm_address_q   <= avm_address_d;
      avm_writedata_q <= avm_writedata_d;
      wait_cnt_q      <= wait_cnt_d;
`ifdef PIO_MASTER_POLL_EN
      op_q      <= op_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      elapsed_q <= elapsed_d;
      gap_cnt_q <= gap_cnt_d;
`endif
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign busy           = busy_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;
  assign avm_chipselect = avm_cs_q;
  assign avm_write_n    = avm_write_n_q;
  assign avm_address    = avm_address_q;
  assign avm_writedata  = avm_writedata_q;

endmodule
